// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache between the decoder fetch port and memctrl.
// One 32-bit word per line; misses fetch a single word via mc_req/mc_ready.
module icache_fetch #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        if_enable,
    input  logic [31:0] if_addr,
    output logic        inst_ready,
    output logic [31:0] inst,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_ready,
    input  logic [31:0] mc_data,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 32 - INDEX_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        DRAIN
    } state_t;

    state_t state_q, state_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [LINES];
    logic [31:0] data_q [LINES];

    logic inst_ready_q, inst_ready_d;
    logic [31:0] inst_q, inst_d;
    logic mc_req_q, mc_req_d;
    logic [31:0] mc_addr_q, mc_addr_d;
    logic [31:0] hit_q, hit_d;
    logic [31:0] miss_q, miss_d;

    logic [INDEX_WIDTH-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [INDEX_WIDTH-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic hit;
    logic fill_en;
    logic unused_addr_lsb;

    assign req_idx  = if_addr[INDEX_WIDTH+1:2];
    assign req_tag  = if_addr[31:INDEX_WIDTH+2];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    // The outstanding miss address doubles as the fill location.
    assign fill_idx = mc_addr_q[INDEX_WIDTH+1:2];
    assign fill_tag = mc_addr_q[31:INDEX_WIDTH+2];
    assign unused_addr_lsb = ^if_addr[1:0];

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        inst_ready_d = inst_ready_q;
        inst_d       = inst_q;
        mc_req_d     = mc_req_q;
        mc_addr_d    = mc_addr_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        fill_en      = 1'b0;
        if (rdy_in) begin
            inst_ready_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!clear && if_enable) begin
                        if (hit) begin
                            inst_ready_d = 1'b1;
                            inst_d       = data_q[req_idx];
                            hit_d        = hit_q + 32'd1;
                        end else begin
                            state_d   = MISS;
                            mc_req_d  = 1'b1;
                            mc_addr_d = {if_addr[31:2], 2'b00};
                            miss_d    = miss_q + 32'd1;
                        end
                    end
                end
                MISS: begin
                    if (mc_ready) begin
                        fill_en  = 1'b1;
                        mc_req_d = 1'b0;
                        state_d  = IDLE;
                        if (!clear) begin
                            inst_ready_d = 1'b1;
                            inst_d       = mc_data;
                        end
                    end else if (clear) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (mc_ready) begin
                        fill_en  = 1'b1;
                        mc_req_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (fill_en) begin
            valid_d[fill_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            inst_ready_q <= 1'b0;
            inst_q       <= '0;
            mc_req_q     <= 1'b0;
            mc_addr_q    <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            inst_ready_q <= inst_ready_d;
            inst_q       <= inst_d;
            mc_req_q     <= mc_req_d;
            mc_addr_q    <= mc_addr_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    // Tag/data storage needs no reset; the valid bits gate every lookup.
    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mc_data;
        end
    end

    assign inst_ready = inst_ready_q;
    assign inst       = inst_q;
    assign mc_req     = mc_req_q;
    assign mc_addr    = mc_addr_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch: a line-level cache model predicts
// every instruction pulse; a monitor pops and compares on inst_ready.
module tb_icache_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        if_enable;
    logic [31:0] if_addr;
    logic        inst_ready;
    logic [31:0] inst;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_ready;
    logic [31:0] mc_data;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache_fetch #(.INDEX_WIDTH(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .clear(clear), .if_enable(if_enable), .if_addr(if_addr),
        .inst_ready(inst_ready), .inst(inst),
        .mc_req(mc_req), .mc_addr(mc_addr),
        .mc_ready(mc_ready), .mc_data(mc_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk_in) cyc = cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    // Model: each line remembers which word address it holds.
    logic [31:0] mem [logic [31:0]];
    bit          m_valid [64];
    logic [29:0] m_wa [64];
    logic [31:0] m_data [64];
    logic [31:0] m_hits = 0;
    logic [31:0] m_misses = 0;

    task automatic check(input string n, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_get(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (!mem.exists(wa)) mem[wa] = $urandom;
        return mem[wa];
    endfunction

    task automatic drive(input bit r, input bit c, input bit en,
                         input logic [31:0] a, input bit mr,
                         input logic [31:0] md);
        rdy_in    = r;
        clear     = c;
        if_enable = en;
        if_addr   = a;
        mc_ready  = mr;
        mc_data   = md;
    endtask

    task automatic push_exp(input logic [31:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + 1;
        exp_q.push_back(e);
    endtask

    always @(negedge clk_in) begin
        if (!rst_in && inst_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_inst_ready: got inst %h expected no pulse", inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("inst", inst, e.data);
                check("inst_cycle", cyc, e.due);
            end
        end
    end

    task automatic do_fetch(input logic [31:0] a, input bit clr,
                            output bit missed);
        int idx;
        idx = int'(a[7:2]);
        missed = 1'b0;
        @(negedge clk_in);
        drive(1'b1, clr, 1'b1, a, 1'b0, 32'h0);
        if (!clr) begin
            if (m_valid[idx] && m_wa[idx] == a[31:2]) begin
                push_exp(m_data[idx]);
                m_hits++;
            end else begin
                missed = 1'b1;
                m_misses++;
            end
        end
        @(posedge clk_in);
        #1;
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
        check("mc_req_after_accept", {31'h0, mc_req}, {31'h0, missed});
        if (missed) check("mc_addr", mc_addr, {a[31:2], 2'b00});
    endtask

    task automatic serve_miss(input logic [31:0] a, input int lat,
                              input int clr_at, input int stalls);
        int done;
        int st;
        bit cleared;
        logic [31:0] d;
        int idx;
        done = 0;
        st = stalls;
        cleared = 1'b0;
        d = mem_get(a);
        idx = int'(a[7:2]);
        while (done < lat || st > 0) begin
            @(negedge clk_in);
            check("mc_req_hold", {31'h0, mc_req}, 32'h1);
            check("mc_addr_hold", mc_addr, {a[31:2], 2'b00});
            if (st > 0 && (($urandom % 2) == 1 || done >= lat)) begin
                drive(1'b0, bit'($urandom % 2), 1'b1, $urandom, 1'b1, $urandom);
                st--;
            end else begin
                drive(1'b1, done == clr_at, 1'b0, 32'h0, 1'b0, 32'h0);
                if (done == clr_at) cleared = 1'b1;
                done++;
            end
            @(posedge clk_in);
        end
        @(negedge clk_in);
        check("mc_req_before_fill", {31'h0, mc_req}, 32'h1);
        drive(1'b1, clr_at == lat, 1'b0, 32'h0, 1'b1, d);
        if (clr_at == lat) cleared = 1'b1;
        if (!cleared) push_exp(d);
        m_valid[idx] = 1'b1;
        m_wa[idx]    = a[31:2];
        m_data[idx]  = d;
        @(posedge clk_in);
        @(negedge clk_in);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("mc_req_after_fill", {31'h0, mc_req}, 32'h0);
        check("miss_count_fill", miss_count, m_misses);
    endtask

    task automatic fetch_serve(input logic [31:0] a, input int lat,
                               input int clr_at, input int stalls);
        bit mi;
        do_fetch(a, 1'b0, mi);
        if (mi) serve_miss(a, lat, clr_at, stalls);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_in);
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        end
    endtask

    initial begin
        bit mi;
        rst_in = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        #1;
        check("rst_inst_ready", {31'h0, inst_ready}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_mc_req", {31'h0, mc_req}, 32'h0);
        check("rst_mc_addr", mc_addr, 32'h0);
        check("rst_hits", hit_count, 32'h0);
        check("rst_misses", miss_count, 32'h0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;

        mem[32'h0000_0000] = 32'h0000_0513;
        mem[32'h0000_0340] = 32'hDEAD_BEEF;

        fetch_serve(32'h0000_0000, 3, -1, 0);
        check("cold_miss_count", miss_count, 32'h1);
        fetch_serve(32'h0000_0004, 1, -1, 0);
        do_fetch(32'h0000_0000, 1'b0, mi);
        do_fetch(32'h0000_0004, 1'b0, mi);
        do_fetch(32'h0000_0000, 1'b0, mi);
        idle(1);
        check("b2b_hit_count", hit_count, 32'h3);

        fetch_serve(32'h0000_0100, 2, -1, 0);
        fetch_serve(32'h0000_0200, 0, -1, 0);
        fetch_serve(32'h0000_0100, 1, -1, 0);

        fetch_serve(32'h0000_0340, 2, 0, 0);
        fetch_serve(32'h0000_0340, 0, -1, 0);
        fetch_serve(32'h0000_0380, 2, 2, 0);
        fetch_serve(32'h0000_0380, 0, -1, 0);

        do_fetch(32'h0000_0340, 1'b1, mi);
        idle(2);

        fetch_serve(32'h0000_03C4, 2, -1, 4);

        do_fetch(32'h0000_03C0, 1'b0, mi);
        idle(1);
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        check("arst_mc_req", {31'h0, mc_req}, 32'h0);
        check("arst_inst_ready", {31'h0, inst_ready}, 32'h0);
        check("arst_hits", hit_count, 32'h0);
        check("arst_misses", miss_count, 32'h0);
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_misses = 0;
        exp_q.delete();
        @(negedge clk_in);
        rst_in = 1'b0;
        fetch_serve(32'h0000_0004, 1, -1, 0);
        check("post_rst_miss", miss_count, 32'h1);

        for (int i = 0; i < 250; i++) begin
            logic [31:0] a;
            int lat;
            int ca;
            int st;
            bit clr;
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2)
                | $urandom_range(0, 3);
            clr = ($urandom_range(0, 7) == 0);
            lat = $urandom_range(0, 4);
            ca = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : -1;
            st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            do_fetch(a, clr, mi);
            if (mi) serve_miss(a, lat, ca, st);
            if ($urandom_range(0, 4) == 0) idle(1);
        end

        idle(3);
        check("pending_expected", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
